// File: rtl/ex_stage.sv
// Execute stage with EX/MEM pipeline register: operand forwarding, single-cycle ALU,
// and an iterative shift-add multiplier that holds upstream stages via busy.
module ex_stage #(
    parameter int MUL_BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] rs1Data,
    input  logic [31:0] rs2Data,
    input  logic [31:0] imm,
    input  logic        ALUSrc,
    input  logic [3:0]  ALUOp,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        memToReg,
    input  logic        regWrite,
    input  logic [4:0]  memWbRd,
    input  logic        memWbRegWrite,
    input  logic [31:0] memWbData,
    output logic [31:0] aluResultOut,
    output logic [31:0] storeDataOut,
    output logic [4:0]  rdOut,
    output logic        memReadOut,
    output logic        memWriteOut,
    output logic        memToRegOut,
    output logic        regWriteOut,
    output logic        busy
);
    localparam int K = MUL_BITS_PER_CYCLE;
    localparam int N = 32 / K;
    localparam logic [4:0] LAST = 5'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] mcand, mplier, acc, pp;
    logic [31:0] sd_q;
    logic [4:0]  rd_q;
    logic        mr_q, mw_q, m2r_q, rw_q;

    logic [31:0] fwd_a, fwd_b, op_b, alu_res;

    // EX/MEM outranks MEM/WB because it holds the younger producer.
    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] rdata);
        if (regWriteOut && rdOut != 5'd0 && rdOut == rs)
            return aluResultOut;
        else if (memWbRegWrite && memWbRd != 5'd0 && memWbRd == rs)
            return memWbData;
        else
            return rdata;
    endfunction

    assign fwd_a = fwd(rs1, rs1Data);
    assign fwd_b = fwd(rs2, rs2Data);
    assign op_b  = ALUSrc ? imm : fwd_b;

    always_comb begin
        alu_res = 32'd0;
        case (ALUOp)
            4'd0: alu_res = fwd_a + op_b;
            4'd1: alu_res = fwd_a - op_b;
            4'd2: alu_res = fwd_a & op_b;
            4'd3: alu_res = fwd_a | op_b;
            4'd4: alu_res = fwd_a ^ op_b;
            4'd5: alu_res = fwd_a << op_b[4:0];
            4'd6: alu_res = fwd_a >> op_b[4:0];
            4'd7: alu_res = $signed(fwd_a) >>> op_b[4:0];
            4'd8: alu_res = {31'd0, $signed(fwd_a) < $signed(op_b)};
            4'd9: alu_res = {31'd0, fwd_a < op_b};
            default: alu_res = 32'd0;
        endcase
    end

    // Partial product for the K low multiplier bits of this iteration.
    always_comb begin
        pp = 32'd0;
        for (int i = 0; i < K; i++)
            if (mplier[i]) pp = pp + (mcand << i);
    end

    assign busy = !reset && ((state == S_IDLE && ALUOp == 4'd10) || state == S_MUL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= 5'd0;
            mcand        <= 32'd0;
            mplier       <= 32'd0;
            acc          <= 32'd0;
            sd_q         <= 32'd0;
            rd_q         <= 5'd0;
            {mr_q, mw_q, m2r_q, rw_q} <= 4'b0;
            aluResultOut <= 32'd0;
            storeDataOut <= 32'd0;
            rdOut        <= 5'd0;
            {memReadOut, memWriteOut, memToRegOut, regWriteOut} <= 4'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ALUOp == 4'd10) begin
                        mcand  <= fwd_a;
                        mplier <= op_b;
                        acc    <= 32'd0;
                        cnt    <= 5'd0;
                        sd_q   <= fwd_b;
                        rd_q   <= rd;
                        {mr_q, mw_q, m2r_q, rw_q} <= {memRead, memWrite, memToReg, regWrite};
                        aluResultOut <= 32'd0;
                        storeDataOut <= 32'd0;
                        rdOut        <= 5'd0;
                        {memReadOut, memWriteOut, memToRegOut, regWriteOut} <= 4'b0;
                        state  <= S_MUL;
                    end else begin
                        aluResultOut <= alu_res;
                        storeDataOut <= fwd_b;
                        rdOut        <= rd;
                        {memReadOut, memWriteOut, memToRegOut, regWriteOut} <=
                            {memRead, memWrite, memToReg, regWrite};
                    end
                end
                S_MUL: begin
                    acc    <= acc + pp;
                    mcand  <= mcand << K;
                    mplier <= mplier >> K;
                    cnt    <= cnt + 5'd1;
                    aluResultOut <= 32'd0;
                    storeDataOut <= 32'd0;
                    rdOut        <= 5'd0;
                    {memReadOut, memWriteOut, memToRegOut, regWriteOut} <= 4'b0;
                    if (cnt == LAST) state <= S_DONE;
                end
                S_DONE: begin
                    // ID/EX still shows the MUL here, so the inputs are not looked at.
                    aluResultOut <= acc;
                    storeDataOut <= sd_q;
                    rdOut        <= rd_q;
                    {memReadOut, memWriteOut, memToRegOut, regWriteOut} <= {mr_q, mw_q, m2r_q, rw_q};
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
